// File: rtl/alu_share_arbiter_if.sv
// Request, ALU and response bundle for the shared-ALU arbiter.
// master = requesters/ALU/consumer side, slave = arbiter.
interface alu_share_arbiter_if #(
   parameter int CTRL_W = 12,
   parameter int DATA_W = 64
);
   logic [1:0]          req_valid;
   logic [1:0]          req_ready;
   logic [2*CTRL_W-1:0] req_control;
   logic [2*DATA_W-1:0] req_src1;
   logic [2*DATA_W-1:0] req_src2;
   logic [CTRL_W-1:0]   alu_control;
   logic [DATA_W-1:0]   alu_src1;
   logic [DATA_W-1:0]   alu_src2;
   logic [DATA_W-1:0]   alu_result;
   logic                resp_valid;
   logic                resp_ready;
   logic                resp_id;
   logic [DATA_W-1:0]   resp_result;
   logic                busy;
   logic [31:0]         op_count;

   modport master (
      output req_valid, req_control, req_src1, req_src2,
      output alu_result, resp_ready,
      input  req_ready, alu_control, alu_src1, alu_src2,
      input  resp_valid, resp_id, resp_result, busy, op_count
   );

   modport slave (
      input  req_valid, req_control, req_src1, req_src2,
      input  alu_result, resp_ready,
      output req_ready, alu_control, alu_src1, alu_src2,
      output resp_valid, resp_id, resp_result, busy, op_count
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters,
// one operation in flight, result returned on a tagged response channel.
module alu_share_arbiter #(
   parameter int CTRL_W = 12,
   parameter int DATA_W = 64
) (
   input logic                clk,
   input logic                resetn,
   alu_share_arbiter_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   state_t              r_state;
   logic                r_prio;
   logic                r_owner;
   logic [CTRL_W-1:0]   r_ctrl;
   logic [DATA_W-1:0]   r_src1;
   logic [DATA_W-1:0]   r_src2;
   logic                r_resp_valid;
   logic                r_resp_id;
   logic [DATA_W-1:0]   r_resp_result;
   logic [31:0]         r_op_count;

   logic [1:0]          w_grant;
   logic                w_accept;
   logic                w_sel;

   // Grant is evaluated fresh every idle cycle; nothing locks a requester.
   always_comb begin
      w_grant = 2'b00;
      if (r_state == S_IDLE) begin
         if (bus.req_valid == 2'b11)
            w_grant = r_prio ? 2'b10 : 2'b01;
         else
            w_grant = bus.req_valid;
      end
   end

   assign w_accept = |(w_grant & bus.req_valid);
   assign w_sel    = w_grant[1];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state       <= S_IDLE;
         r_prio        <= 1'b0;
         r_owner       <= 1'b0;
         r_ctrl        <= '0;
         r_src1        <= '0;
         r_src2        <= '0;
         r_resp_valid  <= 1'b0;
         r_resp_id     <= 1'b0;
         r_resp_result <= '0;
         r_op_count    <= '0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_ctrl  <= w_sel ? bus.req_control[2*CTRL_W-1:CTRL_W]
                                   : bus.req_control[CTRL_W-1:0];
                  r_src1  <= w_sel ? bus.req_src1[2*DATA_W-1:DATA_W]
                                   : bus.req_src1[DATA_W-1:0];
                  r_src2  <= w_sel ? bus.req_src2[2*DATA_W-1:DATA_W]
                                   : bus.req_src2[DATA_W-1:0];
                  r_owner <= w_sel;
                  r_prio  <= ~w_sel;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               r_resp_result <= bus.alu_result;
               r_resp_id     <= r_owner;
               r_resp_valid  <= 1'b1;
               r_state       <= S_RESP;
            end
            S_RESP: begin
               if (r_resp_valid && bus.resp_ready) begin
                  r_resp_valid <= 1'b0;
                  r_op_count   <= r_op_count + 32'd1;
                  r_state      <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_ready   = w_grant;
   assign bus.alu_control = r_ctrl;
   assign bus.alu_src1    = r_src1;
   assign bus.alu_src2    = r_src2;
   assign bus.resp_valid  = r_resp_valid;
   assign bus.resp_id     = r_resp_id;
   assign bus.resp_result = r_resp_result;
   assign bus.busy        = (r_state != S_IDLE);
   assign bus.op_count    = r_op_count;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: directed ops push expected
// responses, an independent monitor pops them on each response handshake.
module tb_alu_share_arbiter;
   localparam int CW = 12;
   localparam int DW = 64;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   alu_share_arbiter_if #(.CTRL_W(CW), .DATA_W(DW)) bus ();

   alu_share_arbiter #(.CTRL_W(CW), .DATA_W(DW)) u_dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   // Small ALU model: 1=add, 2=sub, 3=xor, otherwise and.
   always_comb begin
      case (bus.alu_control)
         12'h001: bus.alu_result = bus.alu_src1 + bus.alu_src2;
         12'h002: bus.alu_result = bus.alu_src1 - bus.alu_src2;
         12'h003: bus.alu_result = bus.alu_src1 ^ bus.alu_src2;
         default: bus.alu_result = bus.alu_src1 & bus.alu_src2;
      endcase
   end

   typedef struct packed {
      logic        id;
      logic [63:0] res;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [11:0] c,
                          input logic [63:0] a, input logic [63:0] b);
      bus.req_control[i*CW +: CW] = c;
      bus.req_src1[i*DW +: DW]    = a;
      bus.req_src2[i*DW +: DW]    = b;
   endtask

   task automatic push(input logic id, input logic [63:0] res);
      exp_t e;
      e.id  = id;
      e.res = res;
      q.push_back(e);
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      while (bus.busy && k < 50) begin
         tick();
         k++;
      end
      check(name, 64'(bus.busy), 64'h0);
   endtask

   task automatic wait_valid(input string name);
      int k = 0;
      while (!bus.resp_valid && k < 50) begin
         tick();
         k++;
      end
      check(name, 64'(bus.resp_valid), 64'h1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      tick();
   endtask

   // Monitor: a response handshake seen here completes on the next edge.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (resetn === 1'b1 && bus.resp_valid && bus.resp_ready) begin
            if (q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_resp: got id=%0d res=%h, want none",
                        bus.resp_id, bus.resp_result);
            end else begin
               e = q.pop_front();
               check("resp_id", 64'(bus.resp_id), 64'(e.id));
               check("resp_result", bus.resp_result, e.res);
            end
         end
      end
   end

   initial begin
      int         n;
      int         t[3];
      logic [1:0] g[3];

      resetn          = 1'b0;
      bus.req_valid   = 2'b00;
      bus.req_control = '0;
      bus.req_src1    = '0;
      bus.req_src2    = '0;
      bus.resp_ready  = 1'b0;
      #12;
      check("rst_resp_valid", 64'(bus.resp_valid), 64'h0);
      check("rst_op_count", 64'(bus.op_count), 64'h0);
      check("rst_alu_ctrl", 64'(bus.alu_control), 64'h0);
      check("rst_busy", 64'(bus.busy), 64'h0);
      @(negedge clk);
      resetn = 1'b1;
      tick();

      // Single op
      set_req(0, 12'h001, 64'h0000_0001_0000_0005, 64'h3);
      bus.resp_ready = 1'b1;
      bus.req_valid  = 2'b01;
      #1;
      check("t1_req_ready", 64'(bus.req_ready), 64'h1);
      push(1'b0, 64'h0000_0001_0000_0008);
      tick();
      bus.req_valid = 2'b00;
      check("t1_busy", 64'(bus.busy), 64'h1);
      check("t1_alu_src1", bus.alu_src1, 64'h0000_0001_0000_0005);
      check("t1_early_valid", 64'(bus.resp_valid), 64'h0);
      tick();
      check("t1_resp_valid", 64'(bus.resp_valid), 64'h1);
      tick();
      check("t1_op_count", 64'(bus.op_count), 64'h1);
      check("t1_idle", 64'(bus.busy), 64'h0);

      // Contention from prio=0
      do_reset();
      set_req(0, 12'h001, 64'd10, 64'd20);
      set_req(1, 12'h002, 64'd100, 64'd1);
      push(1'b0, 64'd30);
      push(1'b1, 64'd99);
      push(1'b0, 64'd30);
      bus.resp_ready = 1'b1;
      bus.req_valid  = 2'b11;
      n = 0;
      for (int i = 0; i < 3; i++) begin
         t[i] = 0;
         g[i] = 2'b00;
      end
      for (int c = 0; c < 30 && n < 3; c++) begin
         #1;
         if (bus.req_ready != 2'b00) begin
            g[n] = bus.req_ready;
            t[n] = c;
            n++;
         end
         tick();
      end
      bus.req_valid = 2'b00;
      check("ct_grants", 64'(n), 64'd3);
      check("ct_g0", 64'(g[0]), 64'h1);
      check("ct_g1", 64'(g[1]), 64'h2);
      check("ct_g2", 64'(g[2]), 64'h1);
      check("ct_gap01", 64'(t[1] - t[0]), 64'd3);
      check("ct_gap12", 64'(t[2] - t[1]), 64'd3);
      wait_idle("ct_idle");
      check("ct_op_count", 64'(bus.op_count), 64'd3);

      // Backpressure
      bus.resp_ready = 1'b0;
      set_req(1, 12'h003, 64'hFF00, 64'h0FF0);
      bus.req_valid = 2'b10;
      push(1'b1, 64'hF0F0);
      wait_valid("bp_valid");
      for (int k = 0; k < 10; k++) begin
         check("bp_valid_hold", 64'(bus.resp_valid), 64'h1);
         check("bp_id_hold", 64'(bus.resp_id), 64'h1);
         check("bp_result_hold", bus.resp_result, 64'hF0F0);
         check("bp_req_ready", 64'(bus.req_ready), 64'h0);
         check("bp_op_count", 64'(bus.op_count), 64'd3);
         tick();
      end
      bus.req_valid  = 2'b00;
      bus.resp_ready = 1'b1;
      tick();
      wait_idle("bp_idle");
      check("bp_op_count_done", 64'(bus.op_count), 64'd4);

      // Withdrawal while busy; prio is 1 after this accept
      bus.resp_ready = 1'b0;
      set_req(0, 12'h004, 64'hF0F0, 64'hFF00);
      bus.req_valid = 2'b01;
      push(1'b0, 64'hF000);
      tick();
      for (int k = 0; k < 4; k++) begin
         bus.req_valid = (k < 2) ? 2'b10 : 2'b00;
         #1;
         check("wd_req_ready", 64'(bus.req_ready), 64'h0);
         tick();
      end
      bus.resp_ready = 1'b1;
      tick();
      bus.resp_ready = 1'b0;
      tick();
      tick();
      set_req(0, 12'h001, 64'd1, 64'd1);
      set_req(1, 12'h002, 64'd5, 64'd7);
      bus.req_valid = 2'b11;
      #1;
      check("wd_saved_prio", 64'(bus.req_ready), 64'h2);
      push(1'b1, 64'hFFFF_FFFF_FFFF_FFFE);
      tick();
      bus.req_valid  = 2'b00;
      bus.resp_ready = 1'b1;
      wait_idle("wd_idle");
      check("wd_op_count", 64'(bus.op_count), 64'd6);

      // Async reset during EXEC; prio is 1 before reset
      set_req(0, 12'h001, 64'd7, 64'd8);
      bus.req_valid = 2'b01;
      tick();
      bus.req_valid = 2'b00;
      #2;
      resetn = 1'b0;
      #1;
      check("ar_alu_ctrl", 64'(bus.alu_control), 64'h0);
      check("ar_alu_src1", bus.alu_src1, 64'h0);
      check("ar_alu_src2", bus.alu_src2, 64'h0);
      check("ar_resp_valid", 64'(bus.resp_valid), 64'h0);
      check("ar_resp_id", 64'(bus.resp_id), 64'h0);
      check("ar_resp_result", bus.resp_result, 64'h0);
      check("ar_op_count", 64'(bus.op_count), 64'h0);
      check("ar_busy", 64'(bus.busy), 64'h0);
      @(negedge clk);
      resetn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("ar_no_resp", 64'(bus.resp_valid), 64'h0);
      end
      set_req(1, 12'h002, 64'd9, 64'd4);
      bus.req_valid = 2'b11;
      #1;
      check("ar_prio_reset", 64'(bus.req_ready), 64'h1);
      push(1'b0, 64'd15);
      tick();
      bus.req_valid = 2'b00;
      wait_idle("ar_idle");
      check("ar_op_count_done", 64'(bus.op_count), 64'd1);

      // op_count wrap
      force u_dut.r_op_count = 32'hFFFF_FFFF;
      #1;
      release u_dut.r_op_count;
      #1;
      check("wr_preload", 64'(bus.op_count), 64'hFFFF_FFFF);
      set_req(1, 12'h001, 64'd2, 64'd2);
      bus.req_valid = 2'b10;
      push(1'b1, 64'd4);
      tick();
      bus.req_valid = 2'b00;
      wait_idle("wr_idle");
      check("wr_op_count", 64'(bus.op_count), 64'h0);

      tick();
      tick();
      check("sb_drained", 64'(q.size()), 64'h0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 64-bit ALU between two requesters, e.g. the touchscreen operand/display front end and a self-test sequencer.
- Arbitrates round-robin and registers the winning operation onto the ALU ports.
- Captures the 64-bit result and returns it on a tagged valid/ready response channel.
- Allows one operation in flight at a time.

Parameters:
CTRL_W, 12, width of the ALU control word
DATA_W, 64, width of ALU operands and result

Ports:
clk  in  1  system clock
resetn  in  1  reset; asynchronous, active-low
req_valid  in  2  per-requester request valid; bit i = requester i
req_ready  out  2  per-requester accept; at most one bit set
req_control  in  2*CTRL_W  control words; requester i at [i*CTRL_W +: CTRL_W]
req_src1  in  2*DATA_W  operand 1; requester i at [i*DATA_W +: DATA_W]
req_src2  in  2*DATA_W  operand 2, same packing
alu_control  out  CTRL_W  registered control to the ALU
alu_src1  out  DATA_W  registered operand 1 to the ALU
alu_src2  out  DATA_W  registered operand 2 to the ALU
alu_result  in  DATA_W  ALU result; combinational from alu_* outputs
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_id  out  1  requester that owns resp_result
resp_result  out  DATA_W  captured result
busy  out  1  high whenever state != IDLE
op_count  out  32  completed operations; wraps 0xFFFFFFFF -> 0

Behaviour:
- Reset (resetn low, asynchronous, any state):
  - state=IDLE, prio=0.
  - alu_control/src1/src2=0, resp_valid=0, resp_id=0, resp_result=0, op_count=0.
  - An in-flight operation is discarded; no response is produced for it.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational and high only in IDLE.
  - Only req_valid[i] high: req_ready=1<<i.
  - Both high: req_ready=1<<prio.
  - Neither high: req_ready=0.
  - Accept = req_valid[i] & req_ready[i]. On accept:
    - register requester i's control/src1/src2 onto the alu_* outputs;
    - owner <= i; prio <= ~i; go to EXEC.
- EXEC (exactly 1 cycle):
  - The ALU settles on the registered operands.
  - At the clock edge: resp_result <= alu_result, resp_id <= owner, resp_valid <= 1; go to RESP.
- RESP:
  - resp_valid, resp_id, resp_result and alu_* hold stable until resp_ready.
  - On resp_valid & resp_ready: resp_valid <= 0, op_count <= op_count+1, go to IDLE.
- Latency:
  - Accept at edge N, result captured at N+1, resp_valid visible after N+1.
  - Minimum issue interval is 3 cycles. A new request can be accepted in the cycle after the response handshake, not the same cycle.
- Requester protocol:
  - A requester may drop req_valid before acceptance; the arbiter re-evaluates every cycle and has no lock.
  - Operands are sampled only at accept and may change afterwards.
- prio changes only on accept, never on idle cycles.
- alu_* outputs keep their last values while IDLE; they are not zeroed.
- resp_ready high outside RESP is ignored.
- op_count wraps silently.

Test Plan:
- Reset then single op: req_valid=01, control=0x001, src1=0x0000_0001_0000_0005, src2=3 (ALU model = add) → req_ready=01 in the same cycle; resp_valid 2 edges later with resp_id=0, resp_result=0x0000_0001_0000_0008; op_count=1 after handshake.
- Contention: req_valid=11 held for three ops, resp_ready=1 → grant order 0,1,0; resp_id sequence 0,1,0; each op takes 3 cycles.
- Backpressure: resp_ready=0 for 10 cycles while req_valid=10 → resp_valid, resp_result and resp_id stable; req_ready=00 throughout; op_count unchanged until resp_ready=1.
- Withdrawal: req_valid[1] pulsed while busy, then dropped → no accept; prio unchanged; next req_valid=11 grants according to the saved prio.
- Async reset in EXEC: resetn low mid-cycle → all outputs 0 immediately, without waiting for a clock edge; no response issued after release; the next request is granted to requester 0 when both are valid.
- Wrap: preload op_count to 0xFFFFFFFF via force/backdoor, complete one op → op_count=0.
